ll_sc_link_unit: RTL
====================

# ll_sc_link_unit

Per-core memory-side responder for the atomic request stream the decoder produces (`dREN`/`dWEN` qualified by `datomic`). It sits between the datapath's data-memory port and the L1 dcache. It holds the load-linked reservation and forwards reads and writes to the cache. It resolves store-conditional success or failure and returns the SC result word on `dload`. Snooped writes from the other core clear the reservation, which gives LL/SC its atomicity across the dual-core system.

## Interface
Parameters:
- `ADDR_W`, 32: address width; the reservation is tracked at word granularity on bits `[ADDR_W-1:2]`.
- `DATA_W`, 32: data width.

Ports:
- `CLK`  in  1  clock; single clock domain.
- `nRST`  in  1  reset, asynchronous, active-low.
- `dREN`  in  1  datapath read request; held until `dhit`.
- `dWEN`  in  1  datapath write request; held until `dhit`.
- `datomic`  in  1  qualifies the request: LL if `dREN`, SC if `dWEN`.
- `daddr`  in  ADDR_W  request address.
- `dstore`  in  DATA_W  store data.
- `halt`  in  1  core halted; clears the reservation and blocks new requests.
- `dhit`  out  1  one-cycle completion pulse to the datapath.
- `dload`  out  DATA_W  read data on loads; SC result (1 or 0) on SC.
- `c_ren`  out  1  cache read request.
- `c_wen`  out  1  cache write request.
- `c_addr`  out  ADDR_W  cache address.
- `c_store`  out  DATA_W  cache write data.
- `c_hit`  in  1  cache completion, level, valid while `c_ren`/`c_wen` is asserted.
- `c_load`  in  DATA_W  cache read data, valid with `c_hit`.
- `snoop_valid`  in  1  the other core is writing or invalidating a block this cycle.
- `snoop_addr`  in  ADDR_W  snooped address.
- `link_valid`  out  1  reservation valid (registered).
- `link_addr`  out  ADDR_W  reserved word address (registered; low 2 bits 0).

## Operation
- States: `IDLE`, `RD`, `WR`, `RESP`.
- Request latching: on the edge leaving `IDLE` with a request, latch `daddr`, `dstore`, `datomic` and the request type into `req_*` registers. `c_addr` and `c_store` are driven from these registers.
- `IDLE` transitions:
  - No request, or `halt` = 1: stay in `IDLE`.
  - `dWEN` = 1 (takes priority over `dREN` if both are asserted) and not SC: go to `WR`.
  - SC that passes: go to `WR` and mark the request as SC-success.
  - SC that fails: go to `RESP` with `dload` = 0 and no cache access.
  - `dREN` = 1: go to `RD`.
- SC pass condition: `link_valid` = 1, `daddr[ADDR_W-1:2]` == `link_addr[ADDR_W-1:2]`, and no matching snoop in the same cycle.
- `RD` state:
  - `c_ren` = 1.
  - On `c_hit`: capture `c_load` into `dload` and go to `RESP`.
  - If the request is LL, also set `link_valid` = 1 and `link_addr` = {`req_addr[ADDR_W-1:2]`, 2'b00}.
- `WR` state:
  - `c_wen` = 1.
  - On `c_hit`: go to `RESP`; `dload` = 1 if SC, otherwise 0.
  - A successful SC clears `link_valid`.
  - A plain SW whose word matches `link_addr` also clears `link_valid`.
- `RESP` state: `dhit` = 1 for exactly one cycle, then go to `IDLE`.
- Reservation clear priority, highest first:
  1. `nRST`
  2. `halt`
  3. matching `snoop_valid`
  4. SC or matching-SW completion
  5. LL set
- An LL completing in the same cycle as a matching snoop leaves `link_valid` = 0.
- A snoop while in `WR` with SC-success does not revoke the SC; the outcome is decided at acceptance and the coherence controller orders the writes.
- A new LL overwrites any existing reservation.

## Timing
- Reset values:
  - State: `IDLE`.
  - All outputs 0: `dhit`, `dload`, `c_ren`, `c_wen`, `c_addr`, `c_store`, `link_valid`, `link_addr`.
- `dhit` and `dload` are registered outputs. `c_ren` and `c_wen` are decoded from the state.
- Latency, with the request asserted in cycle 0:
  - Cache access: `RD`/`WR` in cycle 1, and `dhit` in cycle 1+N when `c_hit` arrives in the N-th cache cycle. Minimum is 2 cycles.
  - SC fail: `dhit` in cycle 1, with no `c_ren` or `c_wen` at any point.
- The request is sampled only in `IDLE`. Changes to `daddr` or `dstore` while in `RD`/`WR`/`RESP` are ignored.
- `halt` asserted mid-transaction lets the current transaction finish; the reservation is cleared on every cycle `halt` = 1.
- `nRST` asserted mid-transaction aborts it immediately: `c_ren`/`c_wen` drop asynchronously and no `dhit` is produced.

## Test plan
- LL 0x100, `c_hit` on the first cycle → `dhit` at cycle 2, `dload` = `c_load`, `link_valid` = 1, `link_addr` = 0x100.
- LL 0x100 then SC 0x100 `dstore` = 0xDEAD → one `c_wen` with `c_addr` = 0x100 and `c_store` = 0xDEAD; `dhit` with `dload` = 1; `link_valid` = 0 afterwards.
- LL 0x100, then `snoop_valid` with `snoop_addr` = 0x104 → reservation kept; then `snoop_addr` = 0x102 (same word) → `link_valid` = 0; following SC 0x100 → `dhit` at cycle 1, `dload` = 0, `c_wen` never asserted.
- LL 0x200, plain SW 0x200 completes → `link_valid` = 0; SC 0x200 fails with `dload` = 0. Repeat with SW to 0x300 → the SC succeeds.
- SC accepted in the same cycle as a matching `snoop_valid` → fails. Snoop arriving one cycle after acceptance (state `WR`) → SC succeeds with `dload` = 1.
- `nRST` pulsed while in `RD` with `c_hit` = 0 → all outputs 0 immediately, state `IDLE`, `link_valid` = 0. Then `halt` = 1 with `dREN` = 1 → no `c_ren` and no `dhit`.

Source files
------------

// File: rtl/ll_sc_link_unit.sv
// ll_sc_link_unit
// Per-core responder between the datapath data port and the L1 dcache.
// Holds the load-linked reservation, forwards reads and writes to the cache,
// resolves store-conditional success at acceptance time and returns the SC
// result word on dload. Snooped writes from the other core break the
// reservation so LL/SC stays atomic across both cores.
module ll_sc_link_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic              datomic,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   input  logic              halt,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   output logic              c_ren,
   output logic              c_wen,
   output logic [ADDR_W-1:0] c_addr,
   output logic [DATA_W-1:0] c_store,
   input  logic              c_hit,
   input  logic [DATA_W-1:0] c_load,
   input  logic              snoop_valid,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              link_valid,
   output logic [ADDR_W-1:0] link_addr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t            state_q, state_d;

   logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
   logic [DATA_W-1:0] reqStore_q, reqStore_d;
   logic              reqAtomic_q, reqAtomic_d;
   logic              reqWrite_q, reqWrite_d;
   logic              scPass_q, scPass_d;

   logic              dhit_q, dhit_d;
   logic [DATA_W-1:0] dload_q, dload_d;

   logic              linkValid_q, linkValid_d;
   logic [ADDR_W-1:0] linkAddr_q, linkAddr_d;

   logic              snoopHitsReq;
   logic              scPasses;
   logic              llComplete;
   logic              wrComplete;
   logic              swHitsLink;
   logic              unusedSnoopLow;

   // The reservation is word-granular, so the byte-offset bits of the snoop
   // address never take part in any comparison.
   assign unusedSnoopLow = ^snoop_addr[1:0];

   // SC acceptance test: the reservation must be live, cover the requested
   // word, and not be broken by a snoop landing on that word this very cycle.
   always_comb begin
      snoopHitsReq = snoop_valid &&
                     (snoop_addr[ADDR_W-1:2] == daddr[ADDR_W-1:2]);
      scPasses     = linkValid_q &&
                     (daddr[ADDR_W-1:2] == linkAddr_q[ADDR_W-1:2]) &&
                     !snoopHitsReq;
      swHitsLink   = (reqAddr_q[ADDR_W-1:2] == linkAddr_q[ADDR_W-1:2]);
   end

   // Next-state and response decode: requests are only sampled in IDLE, a
   // failing SC skips the cache entirely, and dhit/dload are set up so they
   // appear registered in the RESP cycle.
   always_comb begin
      state_d     = state_q;
      reqAddr_d   = reqAddr_q;
      reqStore_d  = reqStore_q;
      reqAtomic_d = reqAtomic_q;
      reqWrite_d  = reqWrite_q;
      scPass_d    = scPass_q;
      dhit_d      = 1'b0;
      dload_d     = dload_q;
      llComplete  = 1'b0;
      wrComplete  = 1'b0;

      case (state_q)
         IDLE: begin
            if (!halt && (dWEN || dREN)) begin
               reqAddr_d   = daddr;
               reqStore_d  = dstore;
               reqAtomic_d = datomic;
               reqWrite_d  = dWEN;
               scPass_d    = 1'b0;
               if (dWEN) begin
                  if (datomic) begin
                     if (scPasses) begin
                        scPass_d = 1'b1;
                        state_d  = WR;
                     end else begin
                        dload_d = '0;
                        dhit_d  = 1'b1;
                        state_d = RESP;
                     end
                  end else begin
                     state_d = WR;
                  end
               end else begin
                  state_d = RD;
               end
            end
         end

         RD: begin
            if (c_hit) begin
               dload_d    = c_load;
               dhit_d     = 1'b1;
               llComplete = reqAtomic_q;
               state_d    = RESP;
            end
         end

         WR: begin
            if (c_hit) begin
               dload_d    = {{(DATA_W-1){1'b0}}, scPass_q};
               dhit_d     = 1'b1;
               wrComplete = 1'b1;
               state_d    = RESP;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reservation update, written lowest priority first so that later
   // statements win: LL set, then SC/matching-SW clear, then a snoop on the
   // (possibly just-set) word, then halt.
   always_comb begin
      linkValid_d = linkValid_q;
      linkAddr_d  = linkAddr_q;

      if (llComplete) begin
         linkValid_d = 1'b1;
         linkAddr_d  = {reqAddr_q[ADDR_W-1:2], 2'b00};
      end

      if (wrComplete && (scPass_q || (!reqAtomic_q && swHitsLink))) begin
         linkValid_d = 1'b0;
      end

      if (snoop_valid &&
          (snoop_addr[ADDR_W-1:2] == linkAddr_d[ADDR_W-1:2])) begin
         linkValid_d = 1'b0;
      end

      if (halt) begin
         linkValid_d = 1'b0;
      end
   end

   // Transaction state, latched request and registered responses; reset
   // aborts any access in flight.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         reqAddr_q   <= '0;
         reqStore_q  <= '0;
         reqAtomic_q <= 1'b0;
         reqWrite_q  <= 1'b0;
         scPass_q    <= 1'b0;
         dhit_q      <= 1'b0;
         dload_q     <= '0;
      end else begin
         state_q     <= state_d;
         reqAddr_q   <= reqAddr_d;
         reqStore_q  <= reqStore_d;
         reqAtomic_q <= reqAtomic_d;
         reqWrite_q  <= reqWrite_d;
         scPass_q    <= scPass_d;
         dhit_q      <= dhit_d;
         dload_q     <= dload_d;
      end
   end

   // Reservation registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         linkValid_q <= 1'b0;
         linkAddr_q  <= '0;
      end else begin
         linkValid_q <= linkValid_d;
         linkAddr_q  <= linkAddr_d;
      end
   end

   // Output drive: cache strobes decode straight from the state so they
   // drop as soon as reset is asserted.
   always_comb begin
      c_ren      = (state_q == RD);
      c_wen      = (state_q == WR) && reqWrite_q;
      c_addr     = reqAddr_q;
      c_store    = reqStore_q;
      dhit       = dhit_q;
      dload      = dload_q;
      link_valid = linkValid_q;
      link_addr  = linkAddr_q;
   end

endmodule
